muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer beside the single-cycle ALU in the EX stage. It executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers. While busy it holds a stall request to the hazard unit. Results are read by MFHI/MFLO via `hi`/`lo`; MTHI/MTLO write them directly.

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
// Optional build macro: MULDIV_FAST_MUL_EN (MULT/MULTU use the native multiplier and skip CALC).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div0_q;
    logic             done_q;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic is_neg);
        return is_neg ? negate(v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                           input logic is_neg);
        return is_neg ? ((~v) + (2*WIDTH)'(1)) : v;
    endfunction

    logic op_signed;
    logic a_neg;
    logic b_neg;

    assign op_signed = ~op[0];
    assign a_neg     = op_signed & src_a[WIDTH-1];
    assign b_neg     = op_signed & src_b[WIDTH-1];

    // One iteration: multiply shifts the product right through {acc,sh}; divide shifts the
    // dividend out of sh into acc and shifts quotient bits into sh.
    logic [WIDTH-1:0] mul_addend_d;
    logic [WIDTH:0]   mul_sum_d;
    logic [WIDTH:0]   div_shift_d;
    logic [WIDTH-1:0] div_sub_d;
    logic             div_geq_d;
    logic [WIDTH-1:0] step_acc_d;
    logic [WIDTH-1:0] step_sh_d;

    always_comb begin
        mul_addend_d = sh_q[0] ? opb_q : {WIDTH{1'b0}};
        mul_sum_d    = {1'b0, acc_q} + {1'b0, mul_addend_d};
        div_shift_d  = {acc_q, sh_q[WIDTH-1]};
        div_sub_d    = div_shift_d[WIDTH-1:0] - opb_q;
        div_geq_d    = (div_shift_d >= {1'b0, opb_q});
        if (is_div_q) begin
            step_acc_d = div_geq_d ? div_sub_d : div_shift_d[WIDTH-1:0];
            step_sh_d  = {sh_q[WIDTH-2:0], div_geq_d};
        end else begin
            step_acc_d = mul_sum_d[WIDTH:1];
            step_sh_d  = {mul_sum_d[0], sh_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_mag_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   res_hi_d;
    logic [WIDTH-1:0]   res_lo_d;

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_mag_d = {{WIDTH{1'b0}}, sh_q} * {{WIDTH{1'b0}}, opb_q};
`else
        prod_mag_d = {acc_q, sh_q};
`endif
        prod_d = apply_sign_wide(prod_mag_d, neg_res_q);
        if (!is_div_q) begin
            res_hi_d = prod_d[2*WIDTH-1:WIDTH];
            res_lo_d = prod_d[WIDTH-1:0];
        end else if (div0_q) begin
            // A zero divisor leaves the dividend magnitude in acc; re-signing it restores src_a.
            res_hi_d = apply_sign(acc_q, neg_rem_q);
            res_lo_d = {WIDTH{1'b1}};
        end else begin
            res_hi_d = apply_sign(acc_q, neg_rem_q);
            res_lo_d = apply_sign(sh_q, neg_res_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        acc_q     <= '0;
                        sh_q      <= apply_sign(src_a, a_neg);
                        opb_q     <= apply_sign(src_b, b_neg);
                        is_div_q  <= op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= op[1] && (src_b == '0);
                        cnt_q     <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        state_q   <= op[1] ? CALC : FIX;
`else
                        state_q   <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= step_acc_d;
                        sh_q  <= step_sh_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_STEP) state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    if (!flush) begin
                        hi_q   <= res_hi_d;
                        lo_q   <= res_lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against a
// behavioural model, and hand-written flush / reset / write-collision sequences.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .src_a(src_a),
        .src_b(src_b),
        .flush(flush),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint p;
        int     sa;
        int     sb;
        sa = a;
        sb = b;
        p  = 0;
        case (o)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                h = p[63:32];
                l = p[31:0];
            end
            2'b01: begin
                p = longint'({32'b0, a}) * longint'({32'b0, b});
                h = p[63:32];
                l = p[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    l = 32'hFFFFFFFF;
                    h = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    l = 32'h80000000;
                    h = 32'h0;
                end else begin
                    l = sa / sb;
                    h = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    l = 32'hFFFFFFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom_range(0, 255);
            1:       v = 32'h0 - $urandom_range(1, 255);
            2:       v = 32'h80000000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Launches an op at the next edge (E0) and returns edges counted from E0 until done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        chk("busy_after_start", 64'(busy), 64'd1);
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        int          exp_lat;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;
        logic        saw_done;

        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[2] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{2'b11, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF};
        vecs[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7] = '{2'b10, 32'hFFFFEDCC, 32'h0,        32'hFFFFEDCC, 32'hFFFFFFFF};
        vecs[8] = '{2'b01, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};

        #2 rst_n = 1'b0;
        #10;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            exp_lat = vecs[i].op[1] ? DIV_LAT : MUL_LAT;
            chk("vec_latency", 64'(cyc), 64'(exp_lat));
            chk("vec_hi", 64'(hi), 64'(vecs[i].hi));
            chk("vec_lo", 64'(lo), 64'(vecs[i].lo));
        end

        @(posedge clk);
        #1;
        chk("done_single_cycle", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);

        start = 1'b1;
        flush = 1'b1;
        op    = 2'b11;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("start_with_flush_ignored", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            model(ro, ra, rb, eh, el);
            run_op(ro, ra, rb, cyc);
            exp_lat = ro[1] ? DIV_LAT : MUL_LAT;
            chk("rand_latency", 64'(cyc), 64'(exp_lat));
            chk("rand_hi", 64'(hi), 64'(eh));
            chk("rand_lo", 64'(lo), 64'(el));
        end

        // MTHI on the same edge as FIX: the divide result must win.
        start = 1'b1;
        op    = 2'b11;
        src_a = 32'd100;
        src_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 33) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        chk("fix_beats_mthi_hi", 64'(hi), 64'd2);
        chk("fix_beats_mthi_lo", 64'(lo), 64'd14);
        chk("fix_beats_mthi_done", 64'(done), 64'd1);

        // MTLO on the same edge as start applies, then the result overwrites it.
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd3;
        src_b = 32'd4;
        lo_we = 1'b1;
        wdata = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        lo_we = 1'b0;
        chk("mtlo_with_start", 64'(lo), 64'h55);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("mtlo_then_result_lo", 64'(lo), 64'd12);
        chk("mtlo_then_result_hi", 64'(hi), 64'd0);

        // Flush mid-divide: HI/LO keep their written values and no done appears.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hAAAA;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mthi_preload", 64'(hi), 64'hAAAA);
        start = 1'b1;
        op    = 2'b10;
        src_a = 32'hFFFFFFF9;
        src_b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 3) begin
                lo_we = 1'b1;
                wdata = 32'h5555;
            end
            if (c == 5) begin
                start = 1'b1;
                op    = 2'b01;
                src_a = 32'd9;
                src_b = 32'd9;
            end
            @(posedge clk);
            #1;
            lo_we = 1'b0;
            start = 1'b0;
            if (c == 3) begin
                chk("mtlo_while_busy", 64'(lo), 64'h5555);
                chk("busy_mid_div", 64'(busy), 64'd1);
            end
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("busy_after_flush", 64'(busy), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("no_done_after_flush", 64'(saw_done), 64'd0);
        chk("hi_kept_after_flush", 64'(hi), 64'hAAAA);
        chk("lo_kept_after_flush", 64'(lo), 64'h5555);
        chk("busy_start_ignored", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a MULT.
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'h00012345;
        src_b = 32'hFFFFFFFD;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_hi", 64'(hi), 64'd0);
        chk("async_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(2'b00, 32'd6, 32'd7, cyc);
        chk("post_rst_latency", 64'(cyc), 64'(MUL_LAT));
        chk("post_rst_lo", 64'(lo), 64'd42);
        chk("post_rst_hi", 64'(hi), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
